program_counter: RTL and testbench



---
 rtl/program_counter.sv | 34 +++
 tb/tb_program_counter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Loadable N-bit up-counter used as the CPU program counter.
// CS low parallel-loads D, CS high counts up; CLR low clears Q asynchronously.
module program_counter #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         CS,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);

    // Zero initialiser gives a defined start value for benches that never pulse CLR.
    logic [N-1:0] q_r = '0;
    logic [N-1:0] q_next;

    always_comb begin
        q_next = q_r + {{(N-1){1'b0}}, 1'b1};
        if (!CS) begin
            q_next = D;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            q_r <= '0;
        end else begin
            q_r <= q_next;
        end
    end

    assign Q = q_r;

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized bench for program_counter against an integer reference model.
module tb_program_counter;

    localparam int N   = 4;
    localparam int MOD = 1 << N;

    logic         CLK;
    logic         CLR;
    logic         CS;
    logic [N-1:0] D;
    logic [N-1:0] Q;

    int checks = 0;
    int errors = 0;
    int model  = 0;

    program_counter #(.N(N)) dut (
        .CLK(CLK),
        .CLR(CLR),
        .CS (CS),
        .D  (D),
        .Q  (Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int expected);
        logic [N-1:0] exp_v;
        exp_v = expected[N-1:0];
        checks++;
        assert (Q === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, Q, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        CLR = 1'b0;
        CS  = 1'b1;
        D   = '0;
        #2;
        check("reset", 0);
        @(negedge CLK);
        CLR = 1'b1;

        for (int i = 1; i <= 10; i++) begin
            step();
            check("free_count", i);
        end

        CS = 1'b0; D = 4'd4;
        step();
        check("load4", 4);

        CS = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("resume_count", 14);

        step(); check("count15", 15);
        step(); check("wrap0", 0);
        step(); check("after_wrap", 1);

        CS = 1'b0; D = 4'd7;
        step();
        check("load7", 7);

        #2 CLR = 1'b0;
        #1 check("async_clear", 0);
        CS = 1'b0; D = 4'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_clear", 0);
        end
        @(negedge CLK);
        CLR = 1'b1; CS = 1'b1;
        step();
        check("release_count", 1);

        CS = 1'b0; D = 4'd3;
        step(); check("reload3", 3);
        D = 4'd12;
        step(); check("reload12", 12);
        #2 D = 4'd5;
        #1 check("d_between_edges", 12);
        step(); check("reload5", 5);

        model = 5;
        for (int i = 0; i < 300; i++) begin
            CS = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            D  = N'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                #1 CLR = 1'b0;
                #1;
                model = 0;
                check("rand_async_clear", model);
                #1 CLR = 1'b1;
            end
            if (CS) model = (model + 1) % MOD;
            else    model = int'(D);
            step();
            check("rand_step", model);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
